snake_motion_unit: RTL
======================

Name: snake_motion_unit

Overview:
- Upstream game-state stage that produces one snake's head position, body segment list and length in the packed form the VGA renderer consumes.
- Each instance samples the direction buttons, advances the snake one board cell per game tick, and grows the snake on an apple hit.
- It detects wall and self collisions.
- The top level instantiates two units, one per snake, and concatenates their outputs into the renderer's data bus.

Parameters:
- TICK_DIV, 2500000: clock cycles per game step (10 steps/s at 25 MHz).
- START_POS, 820: initial head cell (row 20, col 20). Its column must be at least INIT_LEN.
- INIT_LEN, 2: body segments at start, excluding the head.
- MAX_LEN, 10: maximum body segments. Fixed by the 110-bit body bus.

Ports:
- iVGA_CLK  in  1  system/pixel clock; all state is on its rising edge.
- iRST_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins or restarts a game.
- up, down, left, right  in  1 each  level direction buttons.
- apple_pos  in  11  current apple cell (0..1599).
- head_pos  out  11  head cell = 40*row + col.
- body_pos  out  110  segment i in bits [11*i+10 : 11*i]; segment 0 is next to the head.
- length  out  4  valid body segments (0..MAX_LEN).
- ate  out  1  one-cycle pulse on the step where the head enters apple_pos.
- dead  out  1  high while in DEAD.
- running  out  1  high while in RUN.

Behaviour:
- Reset (async, any state) puts the unit in IDLE with these values:
  - head_pos = START_POS; length = INIT_LEN.
  - body segment i = START_POS-1-i for i < INIT_LEN.
  - Unused segments = 11'h7FF (off-board sentinel, never matches a board cell).
  - Direction = right (encoding 0 up, 1 down, 2 left, 3 right).
  - Tick counter = 0; ate = 0, dead = 0, running = 0.
- States:
  - IDLE: on start, go to RUN next cycle.
  - RUN: stepping.
  - DEAD: outputs frozen. On start, reload the reset values (except the state) and enter RUN next cycle.
  - start while in RUN is ignored.
- Tick counter:
  - Counts only in RUN, 0..TICK_DIV-1.
  - A step fires on the cycle the counter equals TICK_DIV-1; the counter wraps to 0 at the same time.
  - First step occurs TICK_DIV cycles after entry to RUN.
- Direction:
  - Buttons are sampled every cycle. With several pressed, priority is up > down > left > right.
  - Sampled direction is written to a pending register unless it is the reverse of the committed direction; reversals are dropped.
  - Pending is copied to committed at each step. The last valid press before a step wins.
- Step computation from the committed direction:
  - Wall: up with row==0, down with row==39, left with col==0, right with col==39 → DEAD. No movement, ate stays 0.
  - Next head: up = head-40, down = head+40, left = head-1, right = head+1. Row/col are derived with divide/modulo by 40, or with tracked row/col registers (preferred: no divider).
  - grow = (next head == apple_pos) && (length < MAX_LEN).
  - Self-collision: next head equals body segment i for some i < length, excluding segment length-1 when grow=0 (the tail vacates) → DEAD, no movement.
  - Otherwise: body[0] <= head, body[i] <= body[i-1], head <= next head. If grow, length+1.
  - Segments with index ≥ new length are forced to 7FF.
- ate pulses for exactly one cycle, the cycle after the step, whenever next head == apple_pos. This includes the case length == MAX_LEN, where there is no growth.
- Simultaneous events:
  - Wall and apple on the same step: wall wins, no ate.
  - Apple on the tail cell with grow=1 counts as self-collision.
- All outputs are registered; they update one cycle after the step cycle.

Decomposition:
- Shared package, snake_pkg, holds:
  - Constants BOARD_W = 40, BOARD_H = 40, POS_W = 11, SEG_NONE = 11'h7FF, MAX_SEGS = 10.
  - Direction encodings DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT.
  - Game-state encodings shared with the renderer's stage field (0 title, 2 play, 3 over).
- One sub-module: snake_dir_filter. It contains the button priority encoder, reversal rejection, the pending register, and commits on a step strobe.

Test Plan:
- Reset, then start, TICK_DIV=4: no button → after 4 cycles head_pos=821, body0=820, body1=819, body2=7FF, length=2.
- Press left while committed right → ignored; next step head_pos=822. Then up, then left before the same step → committed left is legal only after up; head moves 822→782 (up).
- apple_pos=821 at first step → ate high for 1 cycle, length=3, body={820,819,818}, body3=7FF.
- START_POS=839 (col 39), right, start → first step sets dead=1; head_pos stays 839, running=0; a later start reloads and running=1.
- Grow to length 4 and loop down-left-up into the body → DEAD on the collision step. A head entering the current tail cell with no apple → no death.
- Assert iRST_n low mid-RUN, asynchronously between edges → outputs return to reset values immediately, state IDLE, ate=0.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg: constants, encodings and helpers shared by the snake motion
// unit, its direction filter and the VGA renderer.
//   BOARD_W/BOARD_H : board size in cells (cell = 40*row + col)
//   POS_W           : width of one cell index
//   SEG_NONE        : off-board sentinel for unused body segments
//   MAX_SEGS        : number of segment slots on the body bus
//   dir_e           : direction encodings
//   game_state_e    : unit state, encoded to match the renderer stage field
package snake_pkg;
    localparam int BOARD_W  = 40;
    localparam int BOARD_H  = 40;
    localparam int POS_W    = 11;
    localparam int MAX_SEGS = 10;
    localparam int BODY_W   = MAX_SEGS * POS_W;
    localparam logic [POS_W-1:0] SEG_NONE = 11'h7FF;

    typedef logic [POS_W-1:0] pos_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // title
        ST_RUN  = 2'd2,  // play
        ST_DEAD = 2'd3   // over
    } game_state_e;

    // Opposite directions differ only in bit 0 (up/down, left/right).
    function automatic dir_e reverse_of(input dir_e d);
        return dir_e'(d ^ 2'b01);
    endfunction

    // Start-of-game body: a straight line trailing left of the head.
    function automatic logic [BODY_W-1:0] init_body(input int start_pos, input int init_len);
        logic [BODY_W-1:0] b;
        for (int i = 0; i < MAX_SEGS; i++) begin
            b[i*POS_W +: POS_W] = (i < init_len) ? POS_W'(start_pos - 1 - i) : SEG_NONE;
        end
        return b;
    endfunction
endpackage

// File: rtl/snake_motion_unit_if.sv
// snake_motion_unit_if: game-controller side bus of one snake motion unit.
//   master (controller): drives start, up/down/left/right, apple_pos;
//                        receives head_pos, body_pos, length, ate, dead, running
//   slave  (unit)      : the reverse
interface snake_motion_unit_if;
    import snake_pkg::*;

    logic              start;
    logic              up;
    logic              down;
    logic              left;
    logic              right;
    pos_t              apple_pos;
    pos_t              head_pos;
    logic [BODY_W-1:0] body_pos;
    logic [3:0]        length;
    logic              ate;
    logic              dead;
    logic              running;

    modport master (
        output start, up, down, left, right, apple_pos,
        input  head_pos, body_pos, length, ate, dead, running
    );

    modport slave (
        input  start, up, down, left, right, apple_pos,
        output head_pos, body_pos, length, ate, dead, running
    );
endinterface

// File: rtl/snake_dir_filter.sv
// snake_dir_filter: turns level direction buttons into the direction used by
// the next game step.
//   clk, rst_n           : clock, async active-low reset
//   load                 : restart a game (pending = committed = right)
//   step                 : game-step strobe; pending is committed
//   up, down, left, right: level buttons, priority up > down > left > right
//   dir_next             : pending direction, i.e. what the coming step uses
module snake_dir_filter
    import snake_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic step,
    input  logic up,
    input  logic down,
    input  logic left,
    input  logic right,
    output dir_e dir_next
);
    dir_e pending_q, pending_d;
    dir_e committed_q, committed_d;
    dir_e sel;
    logic sel_valid;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        pending_d   = pending_q;
        committed_d = committed_q;
        sel_valid   = up | down | left | right;
        if (up)        sel = DIR_UP;
        else if (down) sel = DIR_DOWN;
        else if (left) sel = DIR_LEFT;
        else           sel = DIR_RIGHT;

        if (load) begin
            pending_d   = DIR_RIGHT;
            committed_d = DIR_RIGHT;
        end else begin
            // Reversal is judged against the direction actually being moved in.
            if (sel_valid && (sel != reverse_of(committed_q))) pending_d = sel;
            if (step) committed_d = pending_q;
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= DIR_RIGHT;
            committed_q <= DIR_RIGHT;
        end else begin
            pending_q   <= pending_d;
            committed_q <= committed_d;
        end
    end

    assign dir_next = pending_q;
endmodule

// File: rtl/snake_motion_unit.sv
// snake_motion_unit: one snake's game state. Steps the head one cell every
// TICK_DIV cycles while running, shifts the body, grows on an apple and
// detects wall / self collisions.
//   iVGA_CLK : clock, all state on its rising edge
//   iRST_n   : async active-low reset
//   bus      : slave side of snake_motion_unit_if (start, buttons, apple_pos in;
//              head_pos, body_pos, length, ate, dead, running out, all registered)
module snake_motion_unit
    import snake_pkg::*;
#(
    parameter int TICK_DIV  = 2500000,
    parameter int START_POS = 820,
    parameter int INIT_LEN  = 2,
    parameter int MAX_LEN   = 10
) (
    input logic               iVGA_CLK,
    input logic               iRST_n,
    snake_motion_unit_if.slave bus
);
    localparam int                TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]     TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [5:0]        START_ROW  = 6'(START_POS / BOARD_W);
    localparam logic [5:0]        START_COL  = 6'(START_POS % BOARD_W);
    localparam logic [BODY_W-1:0] BODY_INIT  = init_body(START_POS, INIT_LEN);
    localparam logic [3:0]        LEN_INIT   = 4'(INIT_LEN);
    localparam logic [3:0]        LEN_MAX    = 4'(MAX_LEN);

    game_state_e       state_q, state_d;
    pos_t              head_q, head_d;
    logic [5:0]        row_q, row_d, col_q, col_d;
    logic [BODY_W-1:0] body_q, body_d;
    logic [3:0]        len_q, len_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic              ate_q, ate_d, dead_q, dead_d, running_q, running_d;

    logic              step, load, wall, hit, grow, self_hit;
    pos_t              next_head;
    logic [5:0]        next_row, next_col;
    logic [3:0]        new_len;
    logic [BODY_W-1:0] moved_body;
    dir_e              dir;

    assign step = (state_q == ST_RUN) && (tick_q == TICK_LAST);
    assign load = (state_q == ST_DEAD) && bus.start;

    snake_dir_filter u_dir (
        .clk      (iVGA_CLK),
        .rst_n    (iRST_n),
        .load     (load),
        .step     (step),
        .up       (bus.up),
        .down     (bus.down),
        .left     (bus.left),
        .right    (bus.right),
        .dir_next (dir)
    );

    // Candidate move; row/col are tracked alongside the cell index so no divider is needed.
    always_comb begin
        next_head = head_q;
        next_row  = row_q;
        next_col  = col_q;
        wall      = 1'b0;
        unique case (dir)
            DIR_UP: begin
                wall = (row_q == 6'd0);
                next_head = head_q - POS_W'(BOARD_W);
                next_row  = row_q - 6'd1;
            end
            DIR_DOWN: begin
                wall = (row_q == 6'(BOARD_H - 1));
                next_head = head_q + POS_W'(BOARD_W);
                next_row  = row_q + 6'd1;
            end
            DIR_LEFT: begin
                wall = (col_q == 6'd0);
                next_head = head_q - POS_W'(1);
                next_col  = col_q - 6'd1;
            end
            DIR_RIGHT: begin
                wall = (col_q == 6'(BOARD_W - 1));
                next_head = head_q + POS_W'(1);
                next_col  = col_q + 6'd1;
            end
        endcase

        hit     = (next_head == bus.apple_pos);
        grow    = hit && (len_q < LEN_MAX);
        new_len = grow ? len_q + 4'd1 : len_q;

        // The tail cell is free unless the snake grows this step.
        self_hit = 1'b0;
        for (int i = 0; i < MAX_SEGS; i++) begin
            if ((4'(i) < len_q) && (grow || (4'(i + 1) != len_q)) &&
                (body_q[i*POS_W +: POS_W] == next_head)) begin
                self_hit = 1'b1;
            end
        end

        moved_body = {body_q[BODY_W-POS_W-1:0], head_q};
        for (int i = 0; i < MAX_SEGS; i++) begin
            if (4'(i) >= new_len) moved_body[i*POS_W +: POS_W] = SEG_NONE;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        row_d   = row_q;
        col_d   = col_q;
        body_d  = body_q;
        len_d   = len_q;
        tick_d  = '0;
        ate_d   = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN: begin
                tick_d = step ? '0 : tick_q + TW'(1);
                if (step) begin
                    if (wall || self_hit) begin
                        state_d = ST_DEAD;
                    end else begin
                        head_d = next_head;
                        row_d  = next_row;
                        col_d  = next_col;
                        body_d = moved_body;
                        len_d  = new_len;
                        ate_d  = hit;
                    end
                end
            end
            ST_DEAD: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    head_d  = POS_W'(START_POS);
                    row_d   = START_ROW;
                    col_d   = START_COL;
                    body_d  = BODY_INIT;
                    len_d   = LEN_INIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        dead_d    = (state_d == ST_DEAD);
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q   <= ST_IDLE;
            head_q    <= POS_W'(START_POS);
            row_q     <= START_ROW;
            col_q     <= START_COL;
            // NOTE: the body is a flop array, not a RAM, so it can and must take a reset value.
            body_q    <= BODY_INIT;
            len_q     <= LEN_INIT;
            tick_q    <= '0;
            ate_q     <= 1'b0;
            dead_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            row_q     <= row_d;
            col_q     <= col_d;
            body_q    <= body_d;
            len_q     <= len_d;
            tick_q    <= tick_d;
            ate_q     <= ate_d;
            dead_q    <= dead_d;
            running_q <= running_d;
        end
    end

    assign bus.head_pos = head_q;
    assign bus.body_pos = body_q;
    assign bus.length   = len_q;
    assign bus.ate      = ate_q;
    assign bus.dead     = dead_q;
    assign bus.running  = running_q;
endmodule
